// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and the hard upper bound on the number of interrupt sources.
package interrupt_controller_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_FORCE   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending sources.
// Source 0 always wins when several requests are present.
module intc_prio_enc
  import interrupt_controller_pkg::*;
(
  input  logic [MAX_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller on the I/O page: edge-detects up to eight
// sources and drives one request at a time on the interrupt/intVect/intAck handshake.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter logic [15:0] VECT_BASE  = 16'h0010,
  parameter int          VECT_SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               io_sel,
  input  logic [1:0]         io_addr,
  input  logic [7:0]         io_wdata,
  input  logic               io_write_en,
  input  logic               io_read_en,
  output logic [7:0]         io_rdata,
  output logic               interrupt,
  output logic [15:0]        intVect,
  input  logic               intAck
);

  state_t state, state_nxt;

  logic [NUM_SRC-1:0] src_q, enable, pending;
  logic [MAX_SRC-1:0] enable_x, pending_x, edge_x, set_x, clr_x, pending_nxt_x;
  logic [2:0]         req_idx, req_idx_nxt, active_idx, active_idx_nxt, enc_idx;
  logic [15:0]        vect_nxt;
  logic [7:0]         rdata_nxt;
  logic               interrupt_nxt, enc_valid, ack_clr, wr, rd;

  assign wr = io_sel & io_write_en;
  assign rd = io_sel & io_read_en;

  // Everything below works on 8-bit views; bits above NUM_SRC stay zero.
  always_comb begin
    enable_x                = '0;
    pending_x               = '0;
    edge_x                  = '0;
    enable_x[NUM_SRC-1:0]   = enable;
    pending_x[NUM_SRC-1:0]  = pending;
    edge_x[NUM_SRC-1:0]     = src & ~src_q;
  end

  // Sets (hardware edge or FORCE) are applied after clears, so a set always wins.
  always_comb begin
    set_x = edge_x;
    clr_x = '0;
    if (wr && io_addr == REG_FORCE)   set_x = set_x | io_wdata;
    if (wr && io_addr == REG_PENDING) clr_x = clr_x | io_wdata;
    if (ack_clr)                      clr_x[req_idx] = 1'b1;
    pending_nxt_x = (pending_x & ~clr_x) | set_x;
  end

  intc_prio_enc u_prio_enc (
    .req   (pending_x & enable_x),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    state_nxt      = state;
    interrupt_nxt  = interrupt;
    vect_nxt       = intVect;
    req_idx_nxt    = req_idx;
    active_idx_nxt = active_idx;
    ack_clr        = 1'b0;
    case (state)
      IDLE: begin
        interrupt_nxt = 1'b0;
        if (enc_valid) begin
          req_idx_nxt   = enc_idx;
          vect_nxt      = VECT_BASE + (16'(enc_idx) << VECT_SHIFT);
          interrupt_nxt = 1'b1;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a simultaneous withdrawal.
        if (intAck) begin
          ack_clr        = 1'b1;
          active_idx_nxt = req_idx;
          interrupt_nxt  = 1'b0;
          state_nxt      = IDLE;
        end else if (!pending_x[req_idx] || !enable_x[req_idx]) begin
          interrupt_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_nxt = io_rdata;
    if (rd) begin
      case (io_addr)
        REG_ENABLE:  rdata_nxt = enable_x;
        REG_PENDING: rdata_nxt = pending_x;
        REG_FORCE:   rdata_nxt = 8'h00;
        REG_STATUS:  rdata_nxt = {(state == REQ), 4'b0000, active_idx};
        default:     rdata_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src_q      <= '0;
      enable     <= '0;
      pending    <= '0;
      req_idx    <= '0;
      active_idx <= '0;
      interrupt  <= 1'b0;
      intVect    <= VECT_BASE;
      io_rdata   <= 8'h00;
    end else begin
      state      <= state_nxt;
      src_q      <= src;
      pending    <= pending_nxt_x[NUM_SRC-1:0];
      req_idx    <= req_idx_nxt;
      active_idx <= active_idx_nxt;
      interrupt  <= interrupt_nxt;
      intVect    <= vect_nxt;
      io_rdata   <= rdata_nxt;
      if (wr && io_addr == REG_ENABLE) enable <= io_wdata[NUM_SRC-1:0];
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with hand-computed
// expectations for reset, priority, withdrawal, ack races and async reset.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  src = '0;
  logic        io_sel = 1'b0;
  logic [1:0]  io_addr = '0;
  logic [7:0]  io_wdata = '0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [7:0]  io_rdata;
  logic        interrupt;
  logic [15:0] intVect;
  logic        intAck = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] readVal;

  interrupt_controller dut (
    .clk         (clk),
    .reset       (reset),
    .src         (src),
    .io_sel      (io_sel),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_write_en (io_write_en),
    .io_read_en  (io_read_en),
    .io_rdata    (io_rdata),
    .interrupt   (interrupt),
    .intVect     (intVect),
    .intAck      (intAck)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ioWrite(input logic [1:0] addr, input logic [7:0] data);
    io_sel = 1'b1; io_write_en = 1'b1; io_addr = addr; io_wdata = data;
    tick();
    io_sel = 1'b0; io_write_en = 1'b0; io_wdata = '0;
  endtask

  task automatic ioRead(input logic [1:0] addr, output logic [7:0] data);
    io_sel = 1'b1; io_read_en = 1'b1; io_addr = addr;
    tick();
    io_sel = 1'b0; io_read_en = 1'b0;
    data = io_rdata;
  endtask

  // One-cycle source pulse; the edge lands in pending at the pulse's clock edge.
  task automatic applyStimulus(input logic [7:0] mask);
    src = mask;
    tick();
    src = '0;
  endtask

  task automatic ackPulse();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    tick(); tick();
    reset = 1'b1;
    tick();

    // T1 reset state
    checkOutput("t1_interrupt", 16'(interrupt), 16'h0000);
    checkOutput("t1_vect", intVect, 16'h0010);
    checkOutput("t1_rdata", 16'(io_rdata), 16'h0000);
    for (int a = 0; a < 4; a++) begin
      ioRead(2'(a), readVal);
      checkOutput($sformatf("t1_reg%0d", a), 16'(readVal), 16'h0000);
    end

    // T2 single source
    ioWrite(2'd0, 8'h04);
    applyStimulus(8'h04);
    checkOutput("t2_int_early", 16'(interrupt), 16'h0000);
    tick();
    checkOutput("t2_int", 16'(interrupt), 16'h0001);
    checkOutput("t2_vect", intVect, 16'h0014);
    ioRead(2'd3, readVal);
    checkOutput("t2_status_req", 16'(readVal), 16'h0080);
    ackPulse();
    checkOutput("t2_int_ack", 16'(interrupt), 16'h0000);
    ioRead(2'd3, readVal);
    checkOutput("t2_status", 16'(readVal), 16'h0002);
    ioRead(2'd1, readVal);
    checkOutput("t2_pending", 16'(readVal), 16'h0000);

    // T3 priority
    ioWrite(2'd0, 8'hFF);
    applyStimulus(8'h22);
    tick();
    checkOutput("t3_int", 16'(interrupt), 16'h0001);
    checkOutput("t3_vect", intVect, 16'h0012);
    ackPulse();
    checkOutput("t3_int_ack", 16'(interrupt), 16'h0000);
    tick();
    checkOutput("t3_int2", 16'(interrupt), 16'h0001);
    checkOutput("t3_vect2", intVect, 16'h001A);
    ackPulse();
    ioRead(2'd1, readVal);
    checkOutput("t3_pending", 16'(readVal), 16'h0000);

    // T4 withdraw via W1C
    ioWrite(2'd0, 8'h08);
    applyStimulus(8'h08);
    tick();
    checkOutput("t4_int", 16'(interrupt), 16'h0001);
    checkOutput("t4_vect", intVect, 16'h0016);
    ioWrite(2'd1, 8'h08);
    checkOutput("t4_int_hold", 16'(interrupt), 16'h0001);
    tick();
    checkOutput("t4_int_withdrawn", 16'(interrupt), 16'h0000);
    ioRead(2'd3, readVal);
    checkOutput("t4_status", 16'(readVal), 16'h0005);

    // T5 ack race and FORCE
    ioWrite(2'd0, 8'h01);
    applyStimulus(8'h01);
    tick();
    checkOutput("t5_int", 16'(interrupt), 16'h0001);
    checkOutput("t5_vect", intVect, 16'h0010);
    intAck = 1'b1; src = 8'h01;
    tick();
    intAck = 1'b0; src = '0;
    checkOutput("t5_int_ack", 16'(interrupt), 16'h0000);
    ioRead(2'd1, readVal);
    checkOutput("t5_pending_kept", 16'(readVal), 16'h0001);
    checkOutput("t5_int_again", 16'(interrupt), 16'h0001);
    ackPulse();
    ioWrite(2'd0, 8'h80);
    ioWrite(2'd2, 8'h80);
    tick();
    checkOutput("t5_force_int", 16'(interrupt), 16'h0001);
    checkOutput("t5_force_vect", intVect, 16'h001E);
    ioRead(2'd2, readVal);
    checkOutput("t5_force_reads0", 16'(readVal), 16'h0000);

    // T6 async reset mid-request
    checkOutput("t6_int_before", 16'(interrupt), 16'h0001);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_int_async", 16'(interrupt), 16'h0000);
    checkOutput("t6_vect_async", intVect, 16'h0010);
    tick();
    reset = 1'b1;
    tick();
    ioRead(2'd1, readVal);
    checkOutput("t6_pending", 16'(readVal), 16'h0000);
    ioRead(2'd0, readVal);
    checkOutput("t6_enable", 16'(readVal), 16'h0000);
    checkOutput("t6_int_after", 16'(interrupt), 16'h0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
